// File: rtl/bnn_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_uart_pkg
//  Description : Shared UART types and constants for the BNN controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package bnn_uart_pkg;

   localparam int c_DATA_BITS     = 8;
   localparam int c_CLKS_PER_BIT  = 87;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bnn_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_rx_fifo
//  Description : First-word-fall-through byte FIFO with full/empty/next-count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_rx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic [WIDTH-1:0]              i_din,
   input  logic                          i_pop,
   output logic [WIDTH-1:0]              o_dout,
   output logic [$clog2(FIFO_DEPTH):0]   o_count_next,
   output logic                          o_full,
   output logic                          o_empty
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic             w_pop;
   logic             w_push;
   logic [c_CW-1:0]  w_count_next;

   assign o_full  = (r_count == c_FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   assign o_count_next = w_count_next;
   assign o_dout       = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bnn_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_uart_rx
//  Description : 8N1 UART receiver with FWFT byte FIFO and CTS flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_uart_rx
   import bnn_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UART_Rx,
   output logic       UART_CTS,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int c_CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_BAUD_W-1:0] c_HALF_LOAD = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_BAUD_W-1:0] c_FULL_LOAD = c_BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]          c_LAST_BIT  = 3'(c_DATA_BITS - 1);
   localparam logic [c_CW-1:0]     c_CTS_LEVEL = c_CW'(FIFO_DEPTH - 1);

   logic                   r_sync1;
   logic                   r_rx_s;
   rx_state_t              r_state;
   logic [c_BAUD_W-1:0]    r_baud;
   logic [2:0]             r_bit_cnt;
   logic [c_DATA_BITS-1:0] r_shift;
   logic                   r_frame_err;
   logic                   r_overrun;
   logic                   r_cts;

   logic                   w_expire;
   logic                   w_push_req;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [c_CW-1:0]        w_count_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= UART_Rx;
         r_rx_s  <= r_sync1;
      end
   end

   assign w_expire   = (r_baud == '0);
   assign w_push_req = (r_state == STOP) && w_expire && r_rx_s;
   assign rx_valid   = !w_empty;
   assign w_pop      = rx_valid && rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_baud      <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_rx_s) begin
                  r_state   <= START;
                  r_bit_cnt <= '0;
                  r_baud    <= c_HALF_LOAD;
               end
            end
            START: begin
               if (w_expire) begin
                  if (r_rx_s) begin
                     r_state <= IDLE;
                  end else begin
                     r_state <= DATA;
                     r_baud  <= c_FULL_LOAD;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            DATA: begin
               if (w_expire) begin
                  // LSB arrives first, so each bit enters at the top and shifts down.
                  r_shift   <= {r_rx_s, r_shift[c_DATA_BITS-1:1]};
                  r_baud    <= c_FULL_LOAD;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == c_LAST_BIT) begin
                     r_state <= STOP;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            STOP: begin
               if (w_expire) begin
                  if (r_rx_s) begin
                     r_overrun <= w_full && !w_pop;
                     r_state   <= IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= WAIT_IDLE;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            WAIT_IDLE: begin
               // A held-low line (break) must return high before a new start is hunted.
               if (r_rx_s) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // CTS looks one entry ahead so a byte already on the wire still fits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cts <= 1'b1;
      end else begin
         r_cts <= (w_count_next >= c_CTS_LEVEL);
      end
   end

   bnn_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (c_DATA_BITS)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push_req),
      .i_din        (r_shift),
      .i_pop        (w_pop),
      .o_dout       (rx_data),
      .o_count_next (w_count_next),
      .o_full       (w_full),
      .o_empty      (w_empty)
   );

   assign UART_CTS  = r_cts;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bnn_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_uart_rx
//  Description : Self-checking bench for bnn_uart_rx with a cycle-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bnn_uart_rx;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   // Edges from the start-bit drive to the stop-bit decision: 2 sync + 1 detect + half bit + 9 bits.
   localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic       uart_cts;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   bnn_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .UART_Rx   (uart_rx),
      .UART_CTS  (uart_cts),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   typedef struct {
      int         e;
      logic [7:0] b;
      bit         ok;
   } ev_t;

   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   bit         chk_en = 1'b0;
   ev_t        ev[$];
   logic [7:0] mq[$];
   bit         m_fe = 1'b0;
   bit         m_ov = 1'b0;
   bit         m_cts = 1'b1;
   logic [7:0] log_b[$];
   int         log_c[$];
   int         fe_cnt = 0;
   int         ov_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: byte completions are scheduled events; the FIFO is a queue.
   initial forever begin : model
      bit  pop;
      bit  push;
      ev_t e;
      @(posedge clk);
      cyc++;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (rst) begin
         mq.delete();
         ev.delete();
         m_cts = 1'b1;
      end else begin
         pop  = (mq.size() > 0) && rx_ready;
         push = 1'b0;
         while (ev.size() > 0 && ev[0].e < cyc) void'(ev.pop_front());
         if (ev.size() > 0 && ev[0].e == cyc) begin
            e = ev.pop_front();
            if (!e.ok)                          m_fe = 1'b1;
            else if (mq.size() < DEPTH || pop)  push = 1'b1;
            else                                m_ov = 1'b1;
         end
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(e.b);
         m_cts = (mq.size() >= DEPTH - 1);
      end
   end

   initial forever begin : compare
      @(negedge clk);
      if (chk_en) begin
         check("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
         check("frame_err", 32'(frame_err), 32'(m_fe));
         check("overrun", 32'(overrun), 32'(m_ov));
         check("UART_CTS", 32'(uart_cts), 32'(m_cts));
         if (rx_valid && rx_ready) begin
            log_b.push_back(rx_data);
            log_c.push_back(cyc);
         end
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      ev_t e;
      e.e  = cyc + LAT;
      e.b  = b;
      e.ok = stop_ok;
      ev.push_back(e);
      uart_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(CPB);
      end
      uart_rx = stop_ok;
      idle(CPB);
   endtask

   task automatic check_log(input string name, input int idx, input logic [7:0] exp);
      if (log_b.size() > idx) check(name, 32'(log_b[idx]), 32'(exp));
      else                    check({name, "_missing"}, 32'(log_b.size()), 32'(idx + 1));
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin : stim
      int s;
      int fe0;
      int ov0;
      idle(1);
      chk_en = 1'b1;
      idle(1);
      check("rst_cts", 32'(uart_cts), 32'd1);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_data", 32'(rx_data), 32'd0);
      check("rst_flags", 32'({frame_err, overrun}), 32'd0);
      rst = 1'b0;
      idle(1);
      check("cts_release", 32'(uart_cts), 32'd0);

      // 1: single byte, consumer ready
      rx_ready = 1'b1;
      log_b.delete(); log_c.delete();
      s = cyc;
      send_frame(8'hA5, 1'b1);
      idle(8);
      check_log("t1_data", 0, 8'hA5);
      if (log_c.size() > 0) check("t1_latency", 32'(log_c[0] - s), 32'd79);
      check("t1_count", 32'(log_b.size()), 32'd1);
      check("t1_flags", 32'(fe_cnt + ov_cnt), 32'd0);

      // 2: glitch shorter than half a bit, then a real frame
      log_b.delete();
      uart_rx = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      idle(12);
      check("t2_nopush", 32'(log_b.size()), 32'd0);
      send_frame(8'h3C, 1'b1);
      idle(8);
      check_log("t2_data", 0, 8'h3C);
      check("t2_flags", 32'(fe_cnt + ov_cnt), 32'd0);

      // 3: framing error followed by a break, then recovery
      log_b.delete();
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      idle(20);
      uart_rx = 1'b1;
      idle(8);
      send_frame(8'h55, 1'b1);
      idle(8);
      check("t3_fe", 32'(fe_cnt - fe0), 32'd1);
      check("t3_count", 32'(log_b.size()), 32'd1);
      check_log("t3_data", 0, 8'h55);

      // 4: fill past capacity with consumer stalled
      log_b.delete();
      rx_ready = 1'b0;
      ov0 = ov_cnt;
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      check("t4_cts_2", 32'(uart_cts), 32'd0);
      send_frame(8'h03, 1'b1);
      check("t4_cts_3", 32'(uart_cts), 32'd1);
      send_frame(8'h04, 1'b1);
      check("t4_ov_4", 32'(ov_cnt - ov0), 32'd0);
      send_frame(8'h05, 1'b1);
      check("t4_ov_5", 32'(ov_cnt - ov0), 32'd1);
      rx_ready = 1'b1;
      idle(10);
      rx_ready = 1'b0;
      check("t4_drained", 32'(log_b.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_log("t4_order", i, 8'(i + 1));
      check("t4_cts_end", 32'(uart_cts), 32'd0);

      // 5: full FIFO, pop coincides with the push
      log_b.delete();
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      fork
         send_frame(8'h99, 1'b1);
         begin
            idle(LAT - 1);
            rx_ready = 1'b1;
            idle(1);
            rx_ready = 1'b0;
         end
      join
      check("t5_no_ov", 32'(ov_cnt - ov0), 32'd0);
      check("t5_full_cts", 32'(uart_cts), 32'd1);
      rx_ready = 1'b1;
      idle(10);
      rx_ready = 1'b0;
      check("t5_count", 32'(log_b.size()), 32'd5);
      check_log("t5_first", 0, 8'h11);
      check_log("t5_fifth", 4, 8'h99);

      // 6: reset during data bit 4 with two bytes queued
      send_frame(8'h66, 1'b1);
      send_frame(8'h77, 1'b1);
      fork
         send_frame(8'hF0, 1'b1);
         begin
            idle(43);
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            check("t6_valid", 32'(rx_valid), 32'd0);
            check("t6_cts_hi", 32'(uart_cts), 32'd1);
            idle(1);
            check("t6_cts_lo", 32'(uart_cts), 32'd0);
         end
      join
      idle(8);
      check("t6_empty", 32'(rx_valid), 32'd0);
      log_b.delete();
      rx_ready = 1'b1;
      send_frame(8'h81, 1'b1);
      idle(8);
      check("t6_count", 32'(log_b.size()), 32'd1);
      check_log("t6_data", 0, 8'h81);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
